// File: rtl/dev_resp_dec.sv
// dev_resp_dec: parses SYNC/CODE/SEQ/CHK device response frames into ACK, NAK, ER_END and FRM_ERR pulses.
// Define DEV_RESP_SEQ_CHK_EN to add sequence-number checking on ACK and erase-done frames.
module dev_resp_dec #(
  parameter logic [7:0] SYNC_BYTE = 8'h5A,
  parameter logic [7:0] CODE_ACK  = 8'h06,
  parameter logic [7:0] CODE_NAK  = 8'h15,
  parameter logic [7:0] CODE_ERE  = 8'h2E,
  parameter int         TO_BITS   = 16
) (
  input  logic       CLK,
  input  logic       RSTB,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  input  logic       RX_ERR,
  input  logic       CLR,
  output logic       ACK,
  output logic       NAK,
  output logic       ER_END,
  output logic       FRM_ERR,
  output logic [7:0] LAST_CODE,
  output logic [7:0] ERR_CNT
);
  typedef enum logic [1:0] {S_HUNT, S_CODE, S_SEQ, S_CHK} state_t;
  state_t state, state_n;
  logic [TO_BITS-1:0] to_cnt, to_cnt_n;
  logic [7:0] code_q, code_n, seq_q, seq_n, last_n, err_n;
  logic [3:0] pls_n;
  logic chk_ok, known, seq_ok, upd, err_inc;
`ifdef DEV_RESP_SEQ_CHK_EN
  logic [7:0] exp_seq, exp_n;
  assign seq_ok = !(code_q == CODE_ACK || code_q == CODE_ERE) || seq_q == exp_seq;
`else
  assign seq_ok = 1'b1;
`endif
  assign chk_ok = (SYNC_BYTE ^ code_q ^ seq_q) == RX_DATA;
  assign known = code_q == CODE_ACK || code_q == CODE_NAK || code_q == CODE_ERE;
  // pls_n packs the next {ACK, NAK, ER_END, FRM_ERR}; only one bit is ever set
  always_comb begin
    state_n = state;
    to_cnt_n = '0;
    code_n = code_q;
    seq_n = seq_q;
    pls_n = '0;
    upd = 1'b0;
    err_inc = 1'b0;
`ifdef DEV_RESP_SEQ_CHK_EN
    exp_n = exp_seq;
`endif
    if (CLR) begin
      state_n = S_HUNT;
`ifdef DEV_RESP_SEQ_CHK_EN
      exp_n = '0;
`endif
    end else if (state != S_HUNT && RX_ERR) begin
      state_n = S_HUNT;
      pls_n = 4'b0001;
    end else if (RX_VALID) begin
      case (state)
        S_HUNT: state_n = RX_DATA == SYNC_BYTE ? S_CODE : S_HUNT;
        S_CODE: begin
          code_n = RX_DATA;
          state_n = S_SEQ;
        end
        S_SEQ: begin
          seq_n = RX_DATA;
          state_n = S_CHK;
        end
        default: begin
          state_n = S_HUNT;
          upd = chk_ok;
          err_inc = chk_ok && !seq_ok;
          pls_n = (!chk_ok || !known) ? 4'b0001 : !seq_ok ? 4'b0100 :
                  {code_q == CODE_ACK, code_q == CODE_NAK, code_q == CODE_ERE, 1'b0};
`ifdef DEV_RESP_SEQ_CHK_EN
          if (chk_ok && seq_ok && (code_q == CODE_ACK || code_q == CODE_ERE)) exp_n = exp_seq + 8'd1;
`endif
        end
      endcase
    end else if (state != S_HUNT) begin
      if (&to_cnt) begin
        state_n = S_HUNT;
        pls_n = 4'b0001;
      end else to_cnt_n = to_cnt + 1'b1;
    end
    err_inc = err_inc || pls_n[0];
    err_n = CLR ? 8'h00 : (err_inc && ERR_CNT != 8'hFF) ? ERR_CNT + 8'd1 : ERR_CNT;
    last_n = CLR ? 8'h00 : upd ? code_q : LAST_CODE;
  end
  always_ff @(posedge CLK or negedge RSTB)
    if (!RSTB) begin
      state <= S_HUNT;
      to_cnt <= '0;
      code_q <= '0;
      seq_q <= '0;
      {ACK, NAK, ER_END, FRM_ERR} <= '0;
      LAST_CODE <= '0;
      ERR_CNT <= '0;
    end else begin
      state <= state_n;
      to_cnt <= to_cnt_n;
      code_q <= code_n;
      seq_q <= seq_n;
      {ACK, NAK, ER_END, FRM_ERR} <= pls_n;
      LAST_CODE <= last_n;
      ERR_CNT <= err_n;
    end
`ifdef DEV_RESP_SEQ_CHK_EN
  always_ff @(posedge CLK or negedge RSTB)
    if (!RSTB) exp_seq <= '0;
    else exp_seq <= exp_n;
`endif
endmodule
